shifter_unit: RTL and testbench
===============================

// Module: shifter_unit
// PURPOSE
// - Single-position shifter on the datapath B operand, ahead of the ALU.
// - Four ops: pass-through, logical left, logical right, arithmetic right (all by 1).
// - Main result shift_out is purely combinational.
// - Registered copy of the result plus status flags is provided for pipelined consumers.
// PARAMETERS
// - WIDTH  default 16  data width in bits; must be >= 2
// PORTS
// - clk         in   1      single clock; all registers rising-edge
// - rst_n       in   1      reset, asynchronous, active-low
// - shift_in    in   WIDTH  operand to shift
// - shift_op    in   2      op select (encoding below)
// - in_valid    in   1      capture strobe for the registered result
// - shift_out   out  WIDTH  combinational result
// - carry_out   out  1      combinational; bit shifted out (0 for pass-through)
// - out_q       out  WIDTH  registered result
// - carry_q     out  1      registered carry_out
// - zero_q      out  1      registered: out_q == 0
// - neg_q       out  1      registered: out_q[WIDTH-1]
// - out_valid   out  1      in_valid delayed one clk
// BEHAVIOUR
// - Op encoding:
//   - 2'b00 NOP: shift_out = shift_in; carry = 0
//   - 2'b01 LSL: shift_out = {shift_in[W-2:0], 1'b0}; carry = shift_in[W-1]
//   - 2'b10 LSR: shift_out = {1'b0, shift_in[W-1:1]}; carry = shift_in[0]
//   - 2'b11 ASR: shift_out = {shift_in[W-1], shift_in[W-1:1]}; carry = shift_in[0]
// - shift_out/carry_out: zero latency, no dependence on clk or rst_n.
//   - Must settle within one combinational delay of any input change.
// - X/Z on shift_op drives shift_out to all-X; never latch the previous value.
// - Registered path, rising clk:
//   - When in_valid=1: out_q, carry_q, zero_q, neg_q load from the current
//     combinational result.
//   - When in_valid=0: these registers hold their value.
//   - out_valid <= in_valid every cycle.
// - Reset: rst_n=0 asynchronously clears out_q=0, carry_q=0, zero_q=1,
//   neg_q=0, out_valid=0.
//   - Mid-operation reset discards the pending capture.
//   - First capture happens on the first rising edge after rst_n deasserts
//     with in_valid=1.
// - Boundary cases:
//   - LSL drops the MSB.
//   - ASR of all-ones stays all-ones.
//   - LSR/ASR of 0 or 1 yields 0.
//   - No wrap-around or rotate.
// STRUCTURE
// - shifter_pkg:
//   - typedef enum logic [1:0] shift_op_t {SH_NOP, SH_LSL, SH_LSR, SH_ASR}
//   - localparam DEFAULT_WIDTH = 16
// - Sub-module shifter_core: combinational (shift_in, shift_op) -> (shift_out, carry_out).
// - shifter_unit instantiates shifter_core and adds the flag and pipeline registers.
// TESTING
// - in=16'h0000, op 00/01/10/11 -> shift_out 0000/0000/0000/0000.
// - in=16'h0008, op 00/01/10/11 -> shift_out 0008/0010/0004/0004.
// - in=16'h0004, op 00/01/10/11 -> shift_out 0004/0008/0002/0002.
// - in=16'hC000, op 00/01/10/11 -> shift_out C000/8000/6000/E000;
//   carry_out 0/1/0/0.
// - Reset / capture sequence:
//   - rst_n=0 mid-run: out_q=0, zero_q=1, out_valid=0 immediately.
//   - Release, then in=16'h8001 op=11 in_valid=1 -> next edge:
//     out_q=C000, carry_q=1, neg_q=1, out_valid=1.
// - Hold: in_valid=0 while inputs change -> out_q unchanged, out_valid=0
//   next edge; shift_out tracks inputs.

Source files
------------

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared op encoding and defaults for the B-operand shifter
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_NOP = 2'b00,
    SH_LSL = 2'b01,
    SH_LSR = 2'b10,
    SH_ASR = 2'b11
  } shift_op_t;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/shifter_core.sv
// rtl/shifter_core.sv - combinational single-position shift with carry-out
module shifter_core
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] shift_in,
  input  logic [1:0]       shift_op,
  output logic [WIDTH-1:0] shift_out,
  output logic             carry_out
);

  always_comb begin
    shift_out = '0;
    carry_out = 1'b0;
    case (shift_op)
      SH_NOP: begin
        shift_out = shift_in;
        carry_out = 1'b0;
      end
      SH_LSL: begin
        shift_out = {shift_in[WIDTH-2:0], 1'b0};
        carry_out = shift_in[WIDTH-1];
      end
      SH_LSR: begin
        shift_out = {1'b0, shift_in[WIDTH-1:1]};
        carry_out = shift_in[0];
      end
      SH_ASR: begin
        shift_out = {shift_in[WIDTH-1], shift_in[WIDTH-1:1]};
        carry_out = shift_in[0];
      end
      // Unknown op poisons the result instead of reusing a stale value
      default: begin
        shift_out = 'x;
        carry_out = 1'bx;
      end
    endcase
  end

endmodule

// File: rtl/shifter_unit.sv
// rtl/shifter_unit.sv - B-operand shifter with registered result and status flags
module shifter_unit
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [1:0]       shift_op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] shift_out,
  output logic             carry_out,
  output logic [WIDTH-1:0] out_q,
  output logic             carry_q,
  output logic             zero_q,
  output logic             neg_q,
  output logic             out_valid
);

  shifter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .shift_in (shift_in),
    .shift_op (shift_op),
    .shift_out(shift_out),
    .carry_out(carry_out)
  );

  // Zero flag resets high so it stays consistent with the cleared out_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b1;
      neg_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q   <= shift_out;
        carry_q <= carry_out;
        zero_q  <= (shift_out == '0);
        neg_q   <= shift_out[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_shifter_unit.sv
// tb/tb_shifter_unit.sv - directed and randomized checks of shifter_unit against an arithmetic model
module tb_shifter_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] shift_in;
  logic [1:0]  shift_op;
  logic        in_valid;
  logic [15:0] shift_out;
  logic        carry_out;
  logic [15:0] out_q;
  logic        carry_q;
  logic        zero_q;
  logic        neg_q;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  int exp_q;
  int exp_c;
  int exp_z;
  int exp_n;
  int exp_v;

  shifter_unit #(
    .WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_in (shift_in),
    .shift_op (shift_op),
    .in_valid (in_valid),
    .shift_out(shift_out),
    .carry_out(carry_out),
    .out_q    (out_q),
    .carry_q  (carry_q),
    .zero_q   (zero_q),
    .neg_q    (neg_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift as multiply/divide by two on unsigned integers
  function automatic int ref_out(input int a, input int op);
    case (op)
      1:       return (a * 2) % 65536;
      2:       return a / 2;
      3:       return a / 2 + ((a >= 32768) ? 32768 : 0);
      default: return a;
    endcase
  endfunction

  function automatic int ref_carry(input int a, input int op);
    case (op)
      1:       return a / 32768;
      2, 3:    return a % 2;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_out_q"},     {16'h0, out_q},     exp_q);
    chk({tag, "_carry_q"},   {31'h0, carry_q},   exp_c);
    chk({tag, "_zero_q"},    {31'h0, zero_q},    exp_z);
    chk({tag, "_neg_q"},     {31'h0, neg_q},     exp_n);
    chk({tag, "_out_valid"}, {31'h0, out_valid}, exp_v);
  endtask

  task automatic model_reset();
    exp_q = 0; exp_c = 0; exp_z = 1; exp_n = 0; exp_v = 0;
  endtask

  task automatic model_edge(input int a, input int op, input int v);
    exp_v = v;
    if (v != 0) begin
      exp_q = ref_out(a, op);
      exp_c = ref_carry(a, op);
      exp_z = (exp_q == 0) ? 1 : 0;
      exp_n = (exp_q >= 32768) ? 1 : 0;
    end
  endtask

  // Drive on the falling edge, check combinational result, then registers after the rising edge
  task automatic step(input string tag, input int a, input int op, input int v);
    @(negedge clk);
    shift_in = a[15:0];
    shift_op = op[1:0];
    in_valid = v[0];
    #1;
    chk({tag, "_shift_out"}, {16'h0, shift_out}, ref_out(a, op));
    chk({tag, "_carry_out"}, {31'h0, carry_out}, ref_carry(a, op));
    @(posedge clk);
    model_edge(a, op, v);
    #1;
    chk_regs(tag);
  endtask

  int dir_in [4] = '{32'h0000, 32'h0008, 32'h0004, 32'hC000};
  int dir_out[16] = '{32'h0000, 32'h0000, 32'h0000, 32'h0000,
                      32'h0008, 32'h0010, 32'h0004, 32'h0004,
                      32'h0004, 32'h0008, 32'h0002, 32'h0002,
                      32'hC000, 32'h8000, 32'h6000, 32'hE000};
  int dir_c  [4] = '{0, 1, 0, 0};

  initial begin
    rst_n    = 1'b0;
    shift_in = '0;
    shift_op = 2'b00;
    in_valid = 1'b0;
    model_reset();
    #12;
    chk_regs("reset");

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      for (int op = 0; op < 4; op++) begin
        @(negedge clk);
        shift_in = dir_in[i][15:0];
        shift_op = op[1:0];
        #1;
        chk($sformatf("dir_%04h_op%0d", dir_in[i], op), {16'h0, shift_out}, dir_out[i*4+op]);
        if (i == 3) chk($sformatf("dir_c000_carry_op%0d", op), {31'h0, carry_out}, dir_c[op]);
      end
    end

    step("bnd_asr_ones", 32'hFFFF, 3, 1);
    step("bnd_lsr_one", 32'h0001, 2, 1);
    step("bnd_asr_one", 32'h0001, 3, 1);
    step("bnd_lsl_msb", 32'h8000, 1, 1);
    step("hold_a", 32'h1234, 1, 0);
    step("hold_b", 32'hA5A5, 3, 0);
    step("cap_nop", 32'h7F00, 0, 1);

    for (int n = 0; n < 300; n++) begin
      step($sformatf("rnd%0d", n), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    // Asynchronous reset between edges with a capture pending
    @(negedge clk);
    shift_in = 16'h5555;
    shift_op = 2'b01;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_regs("async_rst");
    @(posedge clk);
    #1;
    chk_regs("rst_held");

    @(negedge clk);
    rst_n = 1'b1;
    step("first_cap", 32'h8001, 3, 1);
    chk("first_cap_lit_q", {16'h0, out_q}, 32'hC000);
    chk("first_cap_lit_c", {31'h0, carry_q}, 1);
    chk("first_cap_lit_n", {31'h0, neg_q}, 1);
    step("post_hold", 32'h0F0F, 2, 0);
    chk("post_hold_lit_q", {16'h0, out_q}, 32'hC000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
